// File: rtl/light_pkg.sv
// Shared phase/sub-state types, lamp encodings and phase-ring helpers
// for the intersection light sequencer.
package light_pkg;

  localparam int SECS_W = 8;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    INIT,
    NS_GREEN,
    NS_YELLOW,
    RED1,
    EW_GREEN,
    EW_YELLOW,
    RED2,
    FAULT
  } phase_t;

  typedef enum logic {
    SUB_LOAD,
    SUB_RUN
  } sub_t;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    n = FAULT;
    case (p)
      INIT:      n = NS_GREEN;
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = RED1;
      RED1:      n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = RED2;
      RED2:      n = NS_GREEN;
      default:   n = FAULT;
    endcase
    return n;
  endfunction

  function automatic logic is_red(input phase_t p);
    return (p == RED1) || (p == RED2);
  endfunction

  // {ns_lamp, ew_lamp}; INIT and FAULT fall through to all-red.
  function automatic logic [5:0] lamps_of(input phase_t p);
    logic [5:0] l;
    l = {LAMP_R, LAMP_R};
    case (p)
      NS_GREEN:  l = {LAMP_G, LAMP_R};
      NS_YELLOW: l = {LAMP_Y, LAMP_R};
      EW_GREEN:  l = {LAMP_R, LAMP_G};
      EW_YELLOW: l = {LAMP_R, LAMP_Y};
      default:   l = {LAMP_R, LAMP_R};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/reload_handshake.sv
// Timer reload handshake: holds load_n low with the reload value until the
// timer echoes it back, or flags a timeout after ARM_TIMEOUT cycles.
module reload_handshake
  import light_pkg::*;
#(
  parameter int ARM_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SECS_W-1:0] start_secs,
  input  logic [SECS_W-1:0] secs_in,
  output logic              load_n,
  output logic [SECS_W-1:0] load_secs,
  output logic              done,
  output logic              timeout
);

  localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ARM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             echo;

  assign echo    = (secs_in == load_secs);
  assign done    = !load_n && echo;
  // An echo on the final allowed cycle still counts as success.
  assign timeout = !load_n && !echo && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      load_n    <= 1'b1;
      load_secs <= '0;
      cnt       <= '0;
    end else if (start) begin
      load_n    <= 1'b0;
      load_secs <= start_secs;
      cnt       <= '0;
    end else if (done || timeout) begin
      load_n <= 1'b1;
      cnt    <= '0;
    end else if (!load_n) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Two-road intersection phase controller driving a seconds-countdown timer.
// Optional pedestrian early-cut and walk output: define LIGHT_SEQ_PED_EN.
//
// state     | meaning
// INIT      | one cycle after reset, then NS_GREEN load
// NS_GREEN  | north-south green, east-west red
// NS_YELLOW | north-south yellow, east-west red
// RED1      | all-red clearance before east-west green
// EW_GREEN  | east-west green, north-south red
// EW_YELLOW | east-west yellow, north-south red
// RED2      | all-red clearance before north-south green
// FAULT     | timer never echoed a reload; all red until reset
// Ring phases split into SUB_LOAD (handshake) and SUB_RUN (counting down).
module light_sequencer
  import light_pkg::*;
#(
  parameter int NS_GREEN_S  = 30,
  parameter int EW_GREEN_S  = 20,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 1,
  parameter int MIN_GREEN_S = 5,
  parameter int ARM_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SECS_W-1:0] secs_in,
  input  logic              ped_req,
  output logic              load_n,
  output logic [SECS_W-1:0] load_secs,
  output logic [2:0]        ns_lamp,
  output logic [2:0]        ew_lamp,
  output logic              walk,
  output logic              fault
);

  if (NS_GREEN_S < 1 || NS_GREEN_S > 255 || EW_GREEN_S < 1 || EW_GREEN_S > 255 ||
      YELLOW_S < 1 || YELLOW_S > 255 || ALLRED_S < 1 || ALLRED_S > 255 ||
      MIN_GREEN_S < 0 || MIN_GREEN_S > 255 || ARM_TIMEOUT < 1) begin : g_bad_param
    $error("light_sequencer: durations must be 1..255 and ARM_TIMEOUT >= 1");
  end

  localparam logic [SECS_W-1:0] NS_G = SECS_W'(NS_GREEN_S);
  localparam logic [SECS_W-1:0] EW_G = SECS_W'(EW_GREEN_S);
  localparam logic [SECS_W-1:0] YEL  = SECS_W'(YELLOW_S);
  localparam logic [SECS_W-1:0] ARED = SECS_W'(ALLRED_S);

  phase_t            phase_q, phase_d;
  sub_t              sub_q, sub_d;
  logic [5:0]        lamps_q;
  logic              fault_q;
  logic              start;
  logic [SECS_W-1:0] start_secs;
  logic              hs_done, hs_timeout;
  logic              cut;

  reload_handshake #(.ARM_TIMEOUT(ARM_TIMEOUT)) u_reload (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_secs (start_secs),
    .secs_in    (secs_in),
    .load_n     (load_n),
    .load_secs  (load_secs),
    .done       (hs_done),
    .timeout    (hs_timeout)
  );

  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    start   = 1'b0;
    case (phase_q)
      INIT: begin
        phase_d = NS_GREEN;
        sub_d   = SUB_LOAD;
        start   = 1'b1;
      end
      FAULT: phase_d = FAULT;
      default: begin
        if (sub_q == SUB_LOAD) begin
          if (hs_done) sub_d = SUB_RUN;
          else if (hs_timeout) phase_d = FAULT;
        end else if (cut || secs_in == '0) begin
          phase_d = next_phase(phase_q);
          sub_d   = SUB_LOAD;
          start   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    start_secs = '0;
    case (phase_d)
      NS_GREEN:             start_secs = NS_G;
      EW_GREEN:             start_secs = EW_G;
      NS_YELLOW, EW_YELLOW: start_secs = YEL;
      RED1, RED2:           start_secs = ARED;
      default:              start_secs = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= INIT;
      sub_q   <= SUB_LOAD;
      lamps_q <= {LAMP_R, LAMP_R};
      fault_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sub_q   <= sub_d;
      lamps_q <= lamps_of(phase_d);
      fault_q <= (phase_d == FAULT);
    end
  end

  assign ns_lamp = lamps_q[5:3];
  assign ew_lamp = lamps_q[2:0];
  assign fault   = fault_q;

`ifdef LIGHT_SEQ_PED_EN
  localparam logic [SECS_W-1:0] MIN_G = SECS_W'(MIN_GREEN_S);

  logic ped_latch, ped_eff, walk_q;

  // A request arriving this cycle acts as if already latched.
  assign ped_eff = ped_latch | ped_req;
  assign cut     = ped_eff && (phase_q == NS_GREEN || phase_q == EW_GREEN) && (secs_in > MIN_G);

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_latch <= 1'b0;
      walk_q    <= 1'b0;
    end else begin
      if (ped_req) ped_latch <= 1'b1;
      else if (is_red(phase_q) && phase_d != phase_q) ped_latch <= 1'b0;

      if (is_red(phase_d) && phase_d != phase_q) walk_q <= ped_eff;
      else if (!is_red(phase_d)) walk_q <= 1'b0;
    end
  end

  assign walk = walk_q;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign cut        = 1'b0;
  assign walk       = 1'b0;
`endif

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: every output change is popped against
// a queue of hand-computed output vectors and cycle spacings.
module tb_light_sequencer;
  import light_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic [7:0] secs_in = 8'd0;
  logic       echo_en = 1'b1;
  logic       load_n, walk, fault;
  logic [7:0] load_secs;
  logic [2:0] ns_lamp, ew_lamp;

  light_sequencer #(
    .NS_GREEN_S(30), .EW_GREEN_S(20), .YELLOW_S(3), .ALLRED_S(1),
    .MIN_GREEN_S(5), .ARM_TIMEOUT(1023)
  ) dut (
    .clk(clk), .rst(rst), .secs_in(secs_in), .ped_req(ped_req),
    .load_n(load_n), .load_secs(load_secs), .ns_lamp(ns_lamp),
    .ew_lamp(ew_lamp), .walk(walk), .fault(fault)
  );

  always #5 clk = ~clk;

  // Timer model: one second per clock, loads while load_n is low (if echoing).
  always @(posedge clk) begin
    if (rst) secs_in <= 8'd0;
    else if (!load_n && echo_en) secs_in <= load_secs;
    else if (load_n && secs_in != 8'd0) secs_in <= secs_in - 8'd1;
  end

  typedef struct {
    logic [16:0] outs;
    int          delta;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [16:0] prev;
  logic [16:0] mon_cur;
  exp_t        mon_e;

  function automatic logic [16:0] vec(input logic f, input logic w, input logic ln,
                                      input logic [7:0] ls, input logic [2:0] ns,
                                      input logic [2:0] ew);
    return {f, w, ln, ls, ns, ew};
  endfunction

  task automatic push(input string name, input logic [16:0] v, input int d);
    exp_t e;
    e.outs  = v;
    e.delta = d;
    e.name  = name;
    q.push_back(e);
  endtask

  // Monitor: any change of the output bundle is one scoreboard event.
  always @(negedge clk) begin
    cyc++;
    mon_cur = {fault, walk, load_n, load_secs, ns_lamp, ew_lamp};
    if (mon_cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got outs=%h at cycle %0d, want no change", mon_cur, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_cur !== mon_e.outs || (mon_e.delta >= 0 && (cyc - last_cyc) != mon_e.delta)) begin
          errors++;
          $display("FAIL %s: got outs=%h delta=%0d, want outs=%h delta=%0d",
                   mon_e.name, mon_cur, cyc - last_cyc, mon_e.outs, mon_e.delta);
        end
      end
      prev     = mon_cur;
      last_cyc = cyc;
    end
  end

  // Ring with default durations 30/3/1/20/3/1; each phase is LOAD entry then
  // RUN two cycles later, next entry dur+1 cycles after RUN.
  task automatic push_ring(input int first_delta, input int start_idx, input int n);
    logic [16:0] v[13];
    int          d[13];
    string       nm[13];
    v[0]  = vec(0,0,0,8'd30,LAMP_G,LAMP_R); d[0]  = 2;  nm[0]  = "ns_green_load";
    v[1]  = vec(0,0,1,8'd30,LAMP_G,LAMP_R); d[1]  = 2;  nm[1]  = "ns_green_run";
    v[2]  = vec(0,0,0,8'd3, LAMP_Y,LAMP_R); d[2]  = 31; nm[2]  = "ns_yellow_load";
    v[3]  = vec(0,0,1,8'd3, LAMP_Y,LAMP_R); d[3]  = 2;  nm[3]  = "ns_yellow_run";
    v[4]  = vec(0,0,0,8'd1, LAMP_R,LAMP_R); d[4]  = 4;  nm[4]  = "red1_load";
    v[5]  = vec(0,0,1,8'd1, LAMP_R,LAMP_R); d[5]  = 2;  nm[5]  = "red1_run";
    v[6]  = vec(0,0,0,8'd20,LAMP_R,LAMP_G); d[6]  = 2;  nm[6]  = "ew_green_load";
    v[7]  = vec(0,0,1,8'd20,LAMP_R,LAMP_G); d[7]  = 2;  nm[7]  = "ew_green_run";
    v[8]  = vec(0,0,0,8'd3, LAMP_R,LAMP_Y); d[8]  = 21; nm[8]  = "ew_yellow_load";
    v[9]  = vec(0,0,1,8'd3, LAMP_R,LAMP_Y); d[9]  = 2;  nm[9]  = "ew_yellow_run";
    v[10] = vec(0,0,0,8'd1, LAMP_R,LAMP_R); d[10] = 4;  nm[10] = "red2_load";
    v[11] = vec(0,0,1,8'd1, LAMP_R,LAMP_R); d[11] = 2;  nm[11] = "red2_run";
    v[12] = vec(0,0,0,8'd30,LAMP_G,LAMP_R); d[12] = 2;  nm[12] = "ns_green_load_again";
    for (int i = start_idx; i < start_idx + n; i++)
      push(nm[i], v[i], (i == start_idx) ? first_delta : d[i]);
  endtask

  task automatic wait_drain(input int budget, input string what);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expected events pending after %0d cycles, want 0", what, q.size(), budget);
      q.delete();
    end
  endtask

  task automatic wait_secs(input logic [7:0] v, input logic [2:0] ns, input logic [2:0] ew,
                           input string what);
    int n;
    n = 0;
    while (!(secs_in == v && ns_lamp == ns && ew_lamp == ew) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s: secs_in never reached %0d, got %0d", what, v, secs_in);
    end
  endtask

  initial begin
    push("reset", vec(0,0,1,8'd0,LAMP_R,LAMP_R), -1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_ring(-1, 0, 13);
    push_ring(2, 1, 7);
    wait_drain(300, "first_ring");

    // Reset in EW_GREEN.RUN with a dead timer afterwards.
    @(negedge clk);
    push("reset_mid_run", vec(0,0,1,8'd0,LAMP_R,LAMP_R), -1);
    rst     = 1'b1;
    echo_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push("ns_green_load_after_rst", vec(0,0,0,8'd30,LAMP_G,LAMP_R), 1);
    push("fault_after_timeout", vec(1,0,1,8'd30,LAMP_R,LAMP_R), 1023);
    wait_drain(1100, "arm_timeout");

    repeat (20) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || load_n !== 1'b1 || ns_lamp !== LAMP_R || ew_lamp !== LAMP_R) begin
      errors++;
      $display("FAIL fault_sticky: got fault=%b load_n=%b ns=%b ew=%b, want 1 1 100 100",
               fault, load_n, ns_lamp, ew_lamp);
    end

    push("reset_from_fault", vec(0,0,1,8'd0,LAMP_R,LAMP_R), -1);
    rst     = 1'b1;
    echo_en = 1'b1;
`ifndef LIGHT_SEQ_PED_EN
    ped_req = 1'b1;
`endif
    @(negedge clk);
    rst = 1'b0;

`ifdef LIGHT_SEQ_PED_EN
    push("ns_green_load_p", vec(0,0,0,8'd30,LAMP_G,LAMP_R), 1);
    push("ns_green_run_p",  vec(0,0,1,8'd30,LAMP_G,LAMP_R), 2);
    push("ns_yellow_cut",   vec(0,0,0,8'd3, LAMP_Y,LAMP_R), 19);
    push("ns_yellow_run_p", vec(0,0,1,8'd3, LAMP_Y,LAMP_R), 2);
    push("red1_load_walk",  vec(0,1,0,8'd1, LAMP_R,LAMP_R), 4);
    push("red1_run_walk",   vec(0,1,1,8'd1, LAMP_R,LAMP_R), 2);
    push("ew_green_load_p", vec(0,0,0,8'd20,LAMP_R,LAMP_G), 2);
    push("ew_green_run_p",  vec(0,0,1,8'd20,LAMP_R,LAMP_G), 2);
    push("ew_yellow_nocut", vec(0,0,0,8'd3, LAMP_R,LAMP_Y), 21);
    push("ew_yellow_run_p", vec(0,0,1,8'd3, LAMP_R,LAMP_Y), 2);
    push("red2_load_walk",  vec(0,1,0,8'd1, LAMP_R,LAMP_R), 4);
    push("red2_run_walk",   vec(0,1,1,8'd1, LAMP_R,LAMP_R), 2);
    push("ns_green_nowalk", vec(0,0,0,8'd30,LAMP_G,LAMP_R), 2);
    wait_secs(8'd12, LAMP_G, LAMP_R, "ped_wait_12");
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_secs(8'd4, LAMP_R, LAMP_G, "ped_wait_4");
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_drain(300, "ped_ring");
`else
    push_ring(1, 0, 13);
    wait_drain(300, "ring_ped_ignored");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
- Phase controller for a two-road intersection. It sits on the far side of the seconds-countdown timer's reload interface.
- Per phase it drives an active-low reload strobe plus reload value into the timer, and watches the timer's seconds output.
- It advances the NS/EW light phases when the count reaches 0, and drives the one-hot lamp outputs.

Parameters:
- NS_GREEN_S, 30, NS green duration in seconds (1..255)
- EW_GREEN_S, 20, EW green duration in seconds (1..255)
- YELLOW_S, 3, yellow duration in seconds, both roads (1..255)
- ALLRED_S, 1, all-red clearance duration in seconds (1..255)
- MIN_GREEN_S, 5, minimum seconds still left before a pedestrian request may cut green short
- ARM_TIMEOUT, 1023, clk cycles allowed for the timer to echo a reload before FAULT

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- secs_in  in  8  current countdown value from the timer
- ped_req  in  1  pedestrian button, level, already synchronised
- load_n  out  1  active-low reload strobe; the timer loads load_secs unconditionally while low
- load_secs  out  8  reload value, valid while load_n is low
- ns_lamp  out  3  one-hot {red, yellow, green}
- ew_lamp  out  3  one-hot {red, yellow, green}
- walk  out  1  pedestrian walk indicator
- fault  out  1  sticky reload-handshake failure

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: load_n=1, load_secs=0, ns_lamp=3'b100, ew_lamp=3'b100, walk=0, fault=0. State=INIT, ped latch clear, timeout counter 0.
- Phase ring: NS_GREEN -> NS_YELLOW -> RED1 -> EW_GREEN -> EW_YELLOW -> RED2 -> NS_GREEN.
- Each phase has two sub-states, LOAD and RUN.
- INIT -> NS_GREEN.LOAD one cycle after rst deasserts.
- LOAD sub-state:
  - load_n=0, load_secs = phase duration parameter, timeout counter increments.
  - Exit to RUN on the first cycle secs_in == load_secs. On that edge load_n returns to 1 and the counter clears.
  - If the counter reaches ARM_TIMEOUT first -> FAULT.
- RUN sub-state:
  - load_n=1.
  - Advance to the next phase's LOAD on the first cycle secs_in == 0.
- Lamps change on the same edge the phase changes, i.e. on entry to LOAD, not RUN.
- Lamp map:
  - NS_GREEN: ns=G, ew=R
  - NS_YELLOW: ns=Y, ew=R
  - RED1/RED2: both R
  - EW_GREEN: ns=R, ew=G
  - EW_YELLOW: ns=R, ew=Y
- FAULT:
  - Both lamps R, fault=1, load_n=1, walk=0.
  - Absorbing state; only rst leaves it.
- rst asserted mid-phase, including mid-LOAD: next edge restores all reset values; any partial handshake is abandoned.
- Width rules: durations are compared as 8-bit unsigned. A parameter value of 0 is illegal and is rejected at elaboration.
- No simultaneous-event ambiguity: in RUN, an early-cut condition takes priority over secs_in==0. Both lead to the same next state.

Optional Feature:
- Macro: LIGHT_SEQ_PED_EN.
- With the macro defined:
  - ped_req high for any cycle sets a ped latch.
  - In NS_GREEN.RUN or EW_GREEN.RUN with the latch set and secs_in > MIN_GREEN_S, go to the yellow LOAD on the next edge (early cut).
  - With the latch set and secs_in <= MIN_GREEN_S, wait normally.
  - walk=1 throughout RED1 and RED2 whenever the latch was set at that RED phase's entry. The latch clears on leaving that RED phase.
- Without the macro: ped_req is ignored, walk is constant 0, and there is no latch logic.

Decomposition:
- Shared package light_pkg:
  - phase enum (INIT, NS_GREEN, NS_YELLOW, RED1, EW_GREEN, EW_YELLOW, RED2, FAULT)
  - lamp encodings LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001
  - seconds width constant SECS_W=8
- One natural sub-module, reload_handshake. It owns the LOAD-sub-state strobe, the echo compare and the timeout counter, and reports done/timeout to the phase FSM.

Test Plan:
- Reset release with a timer model echoing within 2 cycles -> load_n low with load_secs=30, ns=G, ew=R. Advances to NS_YELLOW LOAD (load_secs=3, ns=Y) one cycle after secs_in hits 0.
- Full ring with durations 3/2/1/1 -> lamp sequence and load_secs values match the phase table; six phase changes, then NS_GREEN again.
- Timer model never echoes -> load_n stays low for 1023 cycles, then fault=1, both lamps R. Holds until rst; rst gives reset values on the next edge.
- rst pulsed while in EW_GREEN.RUN -> next edge: both lamps R, load_n=1. Then NS_GREEN.LOAD the following cycle.
- LIGHT_SEQ_PED_EN: ped_req pulse with secs_in=12 in NS_GREEN.RUN -> NS_YELLOW LOAD next edge, walk=1 during RED1. Same pulse with secs_in=4 -> no cut.
- Without the macro: ped_req held high the whole ring -> timing identical to the no-request run, walk=0.
